// File: rtl/avmm_mem_test_master.sv
// avmm_mem_test_master: Avalon-MM RAM self-test master.
// Writes seed+i over a word range, reads it back and counts mismatches.
module avmm_mem_test_master #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1,
    parameter int ERR_W        = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     word_count,
    input  logic [DATA_W-1:0]   seed,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [ERR_W-1:0]    error_count,
    output logic [ADDR_W-1:0]   first_err_addr,
    output logic [ADDR_W-1:0]   avm_address,
    output logic [DATA_W/8-1:0] avm_byteenable,
    output logic                avm_chipselect,
    output logic                avm_read,
    output logic                avm_write,
    output logic [DATA_W-1:0]   avm_writedata,
    input  logic [DATA_W-1:0]   avm_readdata,
    input  logic                avm_waitrequest
);
    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, FINISH} state_t;
    state_t state;
    logic [ADDR_W:0] cnt, idx;
    logic [ADDR_W-1:0] base;
    logic [DATA_W-1:0] seed_q;
    logic pv [READ_LATENCY];
    logic [DATA_W-1:0] pd [READ_LATENCY];
    logic [ADDR_W-1:0] pa [READ_LATENCY];
    logic accept, last, fail, pending;
    logic [ERR_W-1:0] err_next;

    always_comb begin
        accept   = (avm_write | avm_read) & ~avm_waitrequest;
        last     = idx + 1'b1 == cnt;
        fail     = pv[READ_LATENCY-1] && avm_readdata != pd[READ_LATENCY-1];
        err_next = fail && error_count != '1 ? error_count + 1'b1 : error_count;
        // entries still in flight once this cycle's compare retires
        pending  = 1'b0;
        for (int k = 0; k < READ_LATENCY - 1; k++) pending = pending | pv[k];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            error_count    <= '0;
            first_err_addr <= '0;
            avm_address    <= '0;
            avm_byteenable <= '0;
            avm_chipselect <= 1'b0;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            avm_writedata  <= '0;
            cnt            <= '0;
            idx            <= '0;
            base           <= '0;
            seed_q         <= '0;
            for (int k = 0; k < READ_LATENCY; k++) begin
                pv[k] <= 1'b0;
                pd[k] <= '0;
                pa[k] <= '0;
            end
        end else begin
            done <= 1'b0;
            for (int k = READ_LATENCY - 1; k > 0; k--) begin
                pv[k] <= pv[k-1];
                pd[k] <= pd[k-1];
                pa[k] <= pa[k-1];
            end
            // writedata carries the expected pattern during the read phase
            pv[0] <= avm_read & accept;
            pd[0] <= avm_writedata;
            pa[0] <= avm_address;
            if (fail) begin
                error_count <= err_next;
                if (error_count == '0) first_err_addr <= pa[READ_LATENCY-1];
            end
            case (state)
                IDLE: if (start) begin
                    base           <= base_addr;
                    cnt            <= word_count;
                    seed_q         <= seed;
                    idx            <= '0;
                    error_count    <= '0;
                    first_err_addr <= '0;
                    pass           <= 1'b0;
                    busy           <= 1'b1;
                    if (word_count == '0) state <= FINISH;
                    else begin
                        state          <= WRITE;
                        avm_write      <= 1'b1;
                        avm_chipselect <= 1'b1;
                        avm_byteenable <= '1;
                        avm_address    <= base_addr;
                        avm_writedata  <= seed;
                    end
                end
                WRITE: if (accept) begin
                    avm_address   <= last ? base : avm_address + 1'b1;
                    avm_writedata <= last ? seed_q : avm_writedata + 1'b1;
                    idx           <= last ? '0 : idx + 1'b1;
                    if (last) begin
                        avm_write <= 1'b0;
                        avm_read  <= 1'b1;
                        state     <= READ;
                    end
                end
                READ: if (accept) begin
                    avm_address   <= avm_address + 1'b1;
                    avm_writedata <= avm_writedata + 1'b1;
                    idx           <= idx + 1'b1;
                    if (last) begin
                        avm_read       <= 1'b0;
                        avm_chipselect <= 1'b0;
                        avm_byteenable <= '0;
                        state          <= DRAIN;
                    end
                end
                DRAIN: if (!pending) state <= FINISH;
                FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    pass  <= err_next == '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_avmm_mem_test_master.sv
// tb_avmm_mem_test_master: directed checks of the RAM self-test master
// against a latency-1 stalling slave and a latency-3 slave (ERR_W = 2).
module tb_avmm_mem_test_master;
    logic clk = 0, reset_n = 0, start = 0, start2 = 0;
    logic [11:0] base_addr = 0;
    logic [12:0] word_count = 0;
    logic [31:0] seed = 0;
    int checks = 0, errors = 0;

    logic busy, done, pass, avm_chipselect, avm_read, avm_write, avm_waitrequest;
    logic [15:0] error_count;
    logic [11:0] first_err_addr, avm_address;
    logic [3:0] avm_byteenable;
    logic [31:0] avm_writedata, avm_readdata;

    logic busy2, done2, pass2, cs2, rd2, wr2;
    logic wait2 = 0;
    logic [1:0] err2;
    logic [11:0] fea2, addr2;
    logic [3:0] be2;
    logic [31:0] wd2, rdata2;

    always #5 clk = ~clk;

    avmm_mem_test_master dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .word_count(word_count), .seed(seed), .busy(busy), .done(done), .pass(pass),
        .error_count(error_count), .first_err_addr(first_err_addr),
        .avm_address(avm_address), .avm_byteenable(avm_byteenable),
        .avm_chipselect(avm_chipselect), .avm_read(avm_read), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
        .avm_waitrequest(avm_waitrequest)
    );

    avmm_mem_test_master #(.READ_LATENCY(3), .ERR_W(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .start(start2), .base_addr(base_addr),
        .word_count(word_count), .seed(seed), .busy(busy2), .done(done2), .pass(pass2),
        .error_count(err2), .first_err_addr(fea2),
        .avm_address(addr2), .avm_byteenable(be2),
        .avm_chipselect(cs2), .avm_read(rd2), .avm_write(wr2),
        .avm_writedata(wd2), .avm_readdata(rdata2),
        .avm_waitrequest(wait2)
    );

    // latency-1 slave with programmable stalls and read corruption
    logic [31:0] mem [4096];
    logic [31:0] flip [4096];
    int wr_acc = 0, rd_acc = 0, wcnt = 0, rcnt = 0;
    int sw_idx = -1, sw_n = 0, sr_idx = -1, sr_n = 0, stall_bad = 0, both_bad = 0;
    logic prev_wait = 0;
    logic [11:0] h_a;
    logic [31:0] h_d;

    assign avm_waitrequest = (avm_write && wr_acc == sw_idx && wcnt < sw_n) ||
                             (avm_read && rd_acc == sr_idx && rcnt < sr_n);

    always @(posedge clk) begin
        if (start && !busy) begin
            wr_acc <= 0; rd_acc <= 0; wcnt <= 0; rcnt <= 0;
        end else begin
            if (avm_write && avm_chipselect) begin
                if (avm_waitrequest) wcnt <= wcnt + 1;
                else begin mem[avm_address] <= avm_writedata; wr_acc <= wr_acc + 1; end
            end
            if (avm_read && avm_chipselect) begin
                if (avm_waitrequest) rcnt <= rcnt + 1;
                else begin avm_readdata <= mem[avm_address] ^ flip[avm_address]; rd_acc <= rd_acc + 1; end
            end
        end
        if (prev_wait && (avm_address != h_a || avm_writedata != h_d)) stall_bad <= stall_bad + 1;
        if ((avm_write && avm_read) || (wr2 && rd2)) both_bad <= both_bad + 1;
        prev_wait <= avm_waitrequest;
        h_a <= avm_address;
        h_d <= avm_writedata;
    end

    // latency-3 slave; idle slots return junk so misaligned compares show up
    logic [31:0] mem2 [4096];
    logic [31:0] flip2 [4096];
    logic [31:0] r0, r1, r2;
    assign rdata2 = r2;
    always @(posedge clk) begin
        if (wr2 && cs2) mem2[addr2] <= wd2;
        r0 <= rd2 ? mem2[addr2] ^ flip2[addr2] : 32'h5EED_BEEF;
        r1 <= r0;
        r2 <= r1;
    end

    task automatic go(input bit sel, input logic [11:0] b, input logic [12:0] n,
                      input logic [31:0] s, output int cyc);
        @(negedge clk);
        base_addr = b; word_count = n; seed = s;
        if (sel) start2 = 1; else start = 1;
        @(posedge clk); #1;
        start = 0; start2 = 0; cyc = 1;
        while (!(sel ? done2 : done) && cyc < 2000) begin @(posedge clk); #1; cyc++; end
        checks++;
        if (!(sel ? done2 : done)) begin errors++; $display("FAIL done_timeout sel=%0d cyc=%0d", sel, cyc); end
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({busy, done, pass, error_count, first_err_addr, avm_address, avm_byteenable,
             avm_chipselect, avm_read, avm_write, avm_writedata} !== '0) begin
            errors++; $display("FAIL reset_outputs dut1 not all zero");
        end
        checks++;
        if ({busy2, done2, pass2, err2, fea2, addr2, be2, cs2, rd2, wr2, wd2} !== '0) begin
            errors++; $display("FAIL reset_outputs dut2 not all zero");
        end
        repeat (2) @(negedge clk);
        reset_n = 1;
    endtask

    task automatic test_basic;
        int cyc;
        go(0, 12'h010, 13'd4, 32'hA5A5_0000, cyc);
        checks++; if (cyc !== 11) begin errors++; $display("FAIL basic_latency got %0d want 11", cyc); end
        checks++; if (pass !== 1 || error_count !== 0) begin
            errors++; $display("FAIL basic_result pass=%0d err=%0d want 1/0", pass, error_count); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem[12'h010 + i] !== 32'hA5A5_0000 + i) begin
                errors++; $display("FAIL basic_mem[%0d] got %h want %h", i, mem[12'h010 + i], 32'hA5A5_0000 + i);
            end
        end
        checks++; if (wr_acc !== 4 || rd_acc !== 4) begin
            errors++; $display("FAIL basic_xfers wr=%0d rd=%0d want 4/4", wr_acc, rd_acc); end
    endtask

    task automatic test_fault;
        int cyc;
        flip[12'h012] = 32'h1; flip[12'h013] = 32'h100;
        go(0, 12'h010, 13'd4, 32'hA5A5_0000, cyc);
        flip[12'h012] = 0; flip[12'h013] = 0;
        checks++; if (error_count !== 2) begin errors++; $display("FAIL fault_count got %0d want 2", error_count); end
        checks++; if (first_err_addr !== 12'h012) begin
            errors++; $display("FAIL fault_addr got %h want 012", first_err_addr); end
        checks++; if (pass !== 0) begin errors++; $display("FAIL fault_pass got %0d want 0", pass); end
    endtask

    task automatic test_zero_count;
        int cyc;
        go(0, 12'h123, 13'd0, 32'h0, cyc);
        checks++; if (cyc !== 2) begin errors++; $display("FAIL zero_latency got %0d want 2", cyc); end
        checks++; if (pass !== 1 || error_count !== 0 || first_err_addr !== 0) begin
            errors++; $display("FAIL zero_result pass=%0d err=%0d fea=%h want 1/0/0", pass, error_count, first_err_addr); end
        checks++; if (wr_acc !== 0 || rd_acc !== 0) begin
            errors++; $display("FAIL zero_bus wr=%0d rd=%0d want 0/0", wr_acc, rd_acc); end
    endtask

    task automatic test_waitrequest;
        int cyc;
        sw_idx = 1; sw_n = 3; sr_idx = 2; sr_n = 2;
        go(0, 12'h010, 13'd4, 32'hA5A5_0000, cyc);
        sw_n = 0; sr_n = 0;
        checks++; if (cyc !== 16) begin errors++; $display("FAIL wait_latency got %0d want 16", cyc); end
        checks++; if (wcnt !== 3 || rcnt !== 2) begin
            errors++; $display("FAIL wait_stalls w=%0d r=%0d want 3/2", wcnt, rcnt); end
        checks++; if (stall_bad !== 0) begin errors++; $display("FAIL wait_hold changes=%0d want 0", stall_bad); end
        checks++; if (pass !== 1 || mem[12'h011] !== 32'hA5A5_0001) begin
            errors++; $display("FAIL wait_result pass=%0d mem=%h want 1/a5a50001", pass, mem[12'h011]); end
    endtask

    task automatic test_wrap;
        int cyc;
        logic [11:0] a [4];
        a[0] = 12'hFFE; a[1] = 12'hFFF; a[2] = 12'h000; a[3] = 12'h001;
        go(0, 12'hFFE, 13'd4, 32'h1111_0000, cyc);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem[a[i]] !== 32'h1111_0000 + i) begin
                errors++; $display("FAIL wrap_mem[%h] got %h want %h", a[i], mem[a[i]], 32'h1111_0000 + i);
            end
        end
        checks++; if (pass !== 1 || wr_acc !== 4) begin
            errors++; $display("FAIL wrap_result pass=%0d wr=%0d want 1/4", pass, wr_acc); end
    endtask

    task automatic test_seed_wrap;
        int cyc;
        go(0, 12'h100, 13'd2, 32'hFFFF_FFFF, cyc);
        checks++; if (mem[12'h100] !== 32'hFFFF_FFFF || mem[12'h101] !== 32'h0) begin
            errors++; $display("FAIL seed_wrap got %h %h want ffffffff 00000000", mem[12'h100], mem[12'h101]); end
        checks++; if (pass !== 1) begin errors++; $display("FAIL seed_wrap_pass got %0d want 1", pass); end
    endtask

    task automatic test_start_while_busy;
        int cyc;
        logic seen;
        @(negedge clk);
        base_addr = 12'h200; word_count = 13'd4; seed = 32'h5555_0000; start = 1;
        @(posedge clk); #1; start = 0; cyc = 1;
        repeat (3) begin @(posedge clk); #1; cyc++; end
        checks++; if (busy !== 1) begin errors++; $display("FAIL busy_level got %0d want 1", busy); end
        @(negedge clk);
        base_addr = 12'h300; word_count = 13'd1; start = 1;
        @(posedge clk); #1; start = 0; cyc++;
        while (!done && cyc < 200) begin @(posedge clk); #1; cyc++; end
        checks++; if (cyc !== 11) begin errors++; $display("FAIL busy_start_latency got %0d want 11", cyc); end
        checks++; if (wr_acc !== 4 || rd_acc !== 4 || mem[12'h203] !== 32'h5555_0003) begin
            errors++; $display("FAIL busy_start_xfers wr=%0d rd=%0d mem=%h", wr_acc, rd_acc, mem[12'h203]); end
        seen = 0;
        repeat (3) begin @(posedge clk); #1; seen = seen | busy | done | avm_write | avm_read; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL busy_start_queued activity=%0d want 0", seen); end
    endtask

    task automatic test_reset_mid_read;
        int cyc;
        logic seen;
        @(negedge clk);
        base_addr = 12'h400; word_count = 13'd8; seed = 32'h1234_0000; start = 1;
        @(posedge clk); #1; start = 0; cyc = 0;
        while (!avm_read && cyc < 50) begin @(posedge clk); #1; cyc++; end
        checks++; if (avm_read !== 1) begin errors++; $display("FAIL midrst_reach_read got %0d want 1", avm_read); end
        repeat (2) @(posedge clk);
        @(negedge clk); reset_n = 0; #1;
        checks++;
        if ({busy, done, pass, error_count, first_err_addr, avm_address, avm_byteenable,
             avm_chipselect, avm_read, avm_write, avm_writedata} !== '0) begin
            errors++; $display("FAIL midrst_async outputs not zero read=%0d addr=%h", avm_read, avm_address);
        end
        seen = 0;
        repeat (3) begin @(posedge clk); #1; seen = seen | done; end
        @(negedge clk); reset_n = 1;
        repeat (12) begin @(posedge clk); #1; seen = seen | done | busy; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_done activity=%0d want 0", seen); end
        go(0, 12'h400, 13'd8, 32'h7777_0000, cyc);
        checks++; if (cyc !== 19 || pass !== 1 || error_count !== 0) begin
            errors++; $display("FAIL midrst_rerun cyc=%0d pass=%0d err=%0d want 19/1/0", cyc, pass, error_count); end
        checks++; if (mem[12'h407] !== 32'h7777_0007) begin
            errors++; $display("FAIL midrst_mem got %h want 77770007", mem[12'h407]); end
    endtask

    task automatic test_saturation;
        int cyc;
        for (int i = 0; i < 5; i++) flip2[12'h020 + i] = 32'h1;
        go(1, 12'h020, 13'd6, 32'h3000_0000, cyc);
        for (int i = 0; i < 5; i++) flip2[12'h020 + i] = 0;
        checks++; if (err2 !== 2'd3) begin errors++; $display("FAIL sat_count got %0d want 3", err2); end
        checks++; if (fea2 !== 12'h020 || pass2 !== 0) begin
            errors++; $display("FAIL sat_result fea=%h pass=%0d want 020/0", fea2, pass2); end
        checks++; if (cyc !== 17) begin errors++; $display("FAIL sat_latency got %0d want 17", cyc); end
    endtask

    task automatic test_latency3;
        int cyc;
        go(1, 12'h040, 13'd8, 32'hDEAD_0000, cyc);
        checks++; if (err2 !== 0 || pass2 !== 1 || fea2 !== 0) begin
            errors++; $display("FAIL lat3_result err=%0d pass=%0d fea=%h want 0/1/0", err2, pass2, fea2); end
        checks++; if (cyc !== 21) begin errors++; $display("FAIL lat3_latency got %0d want 21", cyc); end
        checks++; if (mem2[12'h047] !== 32'hDEAD_0007) begin
            errors++; $display("FAIL lat3_mem got %h want dead0007", mem2[12'h047]); end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin flip[i] = 0; flip2[i] = 0; end
        test_reset;
        test_basic;
        test_fault;
        test_zero_count;
        test_waitrequest;
        test_wrap;
        test_seed_wrap;
        test_start_while_busy;
        test_reset_mid_read;
        test_saturation;
        test_latency3;
        checks++; if (both_bad !== 0) begin errors++; $display("FAIL rd_wr_overlap got %0d want 0", both_bad); end
        checks++; if (busy2 !== 0) begin errors++; $display("FAIL final_busy2 got %0d want 0", busy2); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
